// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array input feeder and the PE side.
package systolic_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DONE
    } feeder_state_t;

    typedef logic signed [DATA_W-1:0] operand_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// Per-lane delay chain carrying {valid, data}; DEPTH extra stages behind
// one output register, so total latency is DEPTH+1 clocks.
module skew_line
    import systolic_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_valid,
    input  operand_t i_data,
    output logic     o_valid,
    output operand_t o_data
);

    logic     r_vld [DEPTH+1];
    operand_t r_dat [DEPTH+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s <= DEPTH; s++) begin
                r_vld[s] <= 1'b0;
                r_dat[s] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            r_dat[0] <= i_data;
            for (int s = 1; s <= DEPTH; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_dat[s] <= r_dat[s-1];
            end
        end
    end

    assign o_valid = r_vld[DEPTH];
    assign o_data  = r_dat[DEPTH];

endmodule

// File: rtl/systolic_feeder.sv
// Tile buffer plus diagonal-skew launcher feeding the edge of the PE array.
// Define SYSTOLIC_FEEDER_DBUF_EN for ping-pong buffers that accept writes while busy.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter  int N      = 2,
    parameter  int K      = 4,
    localparam int LANE_W = clog2_min1(N),
    localparam int IDX_W  = clog2_min1(K)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [LANE_W-1:0]    wr_lane,
    input  logic [IDX_W-1:0]     wr_idx,
    input  operand_t             wr_data,
    output logic                 wr_err,
    input  logic                 start,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output operand_t [N-1:0]     a_out,
    output operand_t [N-1:0]     b_out,
    output logic [N-1:0]         a_valid,
    output logic [N-1:0]         b_valid
);

    localparam int              CNT_W = clog2_min1(K + N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K + N - 2);
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    feeder_state_t    r_state;
    feeder_state_t    w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_step;
    logic             w_feed_valid;
    logic             r_done;
    logic             r_wr_err;
    logic             w_wr_in_range;
    logic             w_wr_ok;
    logic             w_wr_bank;
    logic             w_rd_bank;

    operand_t r_a_buf [NBANK][N][K];
    operand_t r_b_buf [NBANK][N][K];
    operand_t w_a_in  [N];
    operand_t w_b_in  [N];

    assign w_wr_in_range = (int'(wr_lane) < N) && (int'(wr_idx) < K);

`ifdef SYSTOLIC_FEEDER_DBUF_EN
    logic r_wbank;
    logic r_rbank;

    // The bank filled so far is launched and the other becomes the shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_rbank <= r_wbank;
            r_wbank <= ~r_wbank;
        end
    end

    assign w_wr_ok   = wr_en && w_wr_in_range;
    assign w_wr_bank = r_wbank;
    assign w_rd_bank = (r_state == IDLE) ? r_wbank : r_rbank;
`else
    assign w_wr_ok   = wr_en && w_wr_in_range && (r_state == IDLE);
    assign w_wr_bank = 1'b0;
    assign w_rd_bank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int i = 0; i < N; i++) begin
                    for (int k = 0; k < K; k++) begin
                        r_a_buf[b][i][k] <= '0;
                        r_b_buf[b][i][k] <= '0;
                    end
                end
            end
        end else if (w_wr_ok) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int i = 0; i < N; i++) begin
                    for (int k = 0; k < K; k++) begin
                        if (w_wr_bank == 1'(b) && int'(wr_lane) == i && int'(wr_idx) == k) begin
                            if (wr_sel) begin
                                r_b_buf[b][i][k] <= wr_data;
                            end else begin
                                r_a_buf[b][i][k] <= wr_data;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // w_step is the lock-step element index entering every skew line this edge.
    always_comb begin
        w_state_next = r_state;
        w_feed_valid = 1'b0;
        w_step       = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = FEED;
                    w_feed_valid = 1'b1;
                end
            end
            FEED: begin
                w_step       = r_cnt + 1'b1;
                w_feed_valid = (int'(r_cnt) + 1) < K;
                if (r_cnt == LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_cnt    <= (r_state == FEED) ? r_cnt + 1'b1 : '0;
            r_done   <= (r_state == FEED) && (r_cnt == LAST);
            r_wr_err <= wr_en && !w_wr_ok;
        end
    end

    // Same-cycle write to the word being launched is forwarded straight in.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_a_in[i] = '0;
            w_b_in[i] = '0;
            for (int b = 0; b < NBANK; b++) begin
                for (int k = 0; k < K; k++) begin
                    if (w_rd_bank == 1'(b) && int'(w_step) == k) begin
                        w_a_in[i] = r_a_buf[b][i][k];
                        w_b_in[i] = r_b_buf[b][i][k];
                    end
                end
            end
            if (w_wr_ok && w_wr_bank == w_rd_bank && int'(wr_idx) == int'(w_step)
                    && int'(wr_lane) == i) begin
                if (wr_sel) begin
                    w_b_in[i] = wr_data;
                end else begin
                    w_a_in[i] = wr_data;
                end
            end
            if (!w_feed_valid) begin
                w_a_in[i] = '0;
                w_b_in[i] = '0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            skew_line #(.DEPTH(gi)) u_a_skew (
                .clk     (clk),
                .reset   (reset),
                .i_valid (w_feed_valid),
                .i_data  (w_a_in[gi]),
                .o_valid (a_valid[gi]),
                .o_data  (a_out[gi])
            );
            skew_line #(.DEPTH(gi)) u_b_skew (
                .clk     (clk),
                .reset   (reset),
                .i_valid (w_feed_valid),
                .i_data  (w_b_in[gi]),
                .o_valid (b_valid[gi]),
                .o_data  (b_out[gi])
            );
        end
    endgenerate

    assign ready  = (r_state == IDLE);
    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign wr_err = r_wr_err;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with N=2, K=3.
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int N = 2;
    localparam int K = 3;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wr_en = 1'b0;
    logic             wr_sel = 1'b0;
    logic [0:0]       wr_lane = '0;
    logic [1:0]       wr_idx = '0;
    operand_t         wr_data = '0;
    logic             wr_err;
    logic             start = 1'b0;
    logic             ready;
    logic             busy;
    logic             done;
    operand_t [N-1:0] a_out;
    operand_t [N-1:0] b_out;
    logic [N-1:0]     a_valid;
    logic [N-1:0]     b_valid;

    int n_checks = 0;
    int n_pass   = 0;

    systolic_feeder #(.N(N), .K(K)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_lane (wr_lane),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_err  (wr_err),
        .start   (start),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .a_out   (a_out),
        .b_out   (b_out),
        .a_valid (a_valid),
        .b_valid (b_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
            $display("ok   %s: %0d", tag, got);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int lane, input int idx, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_lane = 1'(lane);
        wr_idx  = 2'(idx);
        wr_data = 8'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic feed_chk(input string tag, input int a0, input int a1, input int av,
                            input int b0, input int b1, input int bv);
        check({tag, "_a0"}, int'(a_out[0]), a0);
        check({tag, "_a1"}, int'(a_out[1]), a1);
        check({tag, "_av"}, int'(a_valid), av);
        check({tag, "_b0"}, int'(b_out[0]), b0);
        check({tag, "_b1"}, int'(b_out[1]), b1);
        check({tag, "_bv"}, int'(b_valid), bv);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_wait"}, int'(ready), 1);
    endtask

    initial begin
        int first_c0;
        // Reset values
        tick();
        tick();
        check("rst_aout", int'(a_out), 0);
        check("rst_bout", int'(b_out), 0);
        check("rst_valid", int'({a_valid, b_valid}), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr_err", int'(wr_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(ready), 1);
        reset = 1'b0;
        tick();

        // Basic tile
        wr(0, 0, 0, 1);  wr(0, 0, 1, 2);  wr(0, 0, 2, 3);
        wr(0, 1, 0, 4);  wr(0, 1, 1, 5);  wr(0, 1, 2, 6);
        wr(1, 0, 0, -1); wr(1, 0, 1, -2); wr(1, 0, 2, -3);
        wr(1, 1, 0, 7);  wr(1, 1, 1, 8);  wr(1, 1, 2, 9);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_chk("t1_c0", 1, 0, 1, -1, 0, 1);
        check("t1_c0_busy", int'(busy), 1);
        check("t1_c0_ready", int'(ready), 0);
        tick();
        feed_chk("t1_c1", 2, 4, 3, -2, 7, 3);
        tick();
        feed_chk("t1_c2", 3, 5, 3, -3, 8, 3);
        tick();
        feed_chk("t1_c3", 0, 6, 2, 0, 9, 2);
        check("t1_c3_done", int'(done), 0);
        tick();
        check("t1_done", int'(done), 1);
        check("t1_done_valid", int'({a_valid, b_valid}), 0);
        check("t1_done_ready", int'(ready), 0);
        tick();
        check("t1_ready", int'(ready), 1);
        check("t1_done_drop", int'(done), 0);

        // Write and start in the same cycle: overwrite A0[0] with -128
        wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 1'b0; wr_idx = 2'd0; wr_data = 8'h80;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        check("t2_c0_a0", int'(a_out[0]), -128);
        check("t2_c0_a1", int'(a_out[1]), 0);
        check("t2_c0_av", int'(a_valid), 1);
        wait_ready("t2");

        // Out-of-range index is dropped
        wr(0, 1, 3, 99);
        check("bad_idx_wr_err", int'(wr_err), 1);
        tick();
        check("bad_idx_wr_err_clear", int'(wr_err), 0);

        // Tile 3, with a write attempted during FEED
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_chk("t3_c0", DBUF ? 1 : -128, 0, 1, -1, 0, 1);
        wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 1'b1; wr_idx = 2'd0; wr_data = 8'sd50;
        tick();
        wr_en = 1'b0;
        check("feed_wr_err", int'(wr_err), DBUF ? 0 : 1);
        check("t3_c1_a1", int'(a_out[1]), 4);
        tick();
        check("t3_c2_a1", int'(a_out[1]), 5);
        tick();
        check("t3_c3_a1", int'(a_out[1]), 6);
        check("t3_c3_av", int'(a_valid), 2);
        wait_ready("t3");

        // Tile 4, reset at c1
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t4_c1_a0", int'(a_out[0]), DBUF ? 0 : 2);
        check("t4_c1_a1", int'(a_out[1]), DBUF ? 50 : 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_aout", int'(a_out), 0);
        check("mid_rst_valid", int'({a_valid, b_valid}), 0);
        check("mid_rst_ready", int'(ready), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);

        // Tile 5 without reload: zeros with the valid pattern intact
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_chk("t5_c0", 0, 0, 1, 0, 0, 1);
        tick();
        feed_chk("t5_c1", 0, 0, 3, 0, 0, 3);
        tick();
        tick();
        feed_chk("t5_c3", 0, 0, 2, 0, 0, 2);
        tick();
        check("t5_done", int'(done), 1);
        wait_ready("t5");

        // Start held high: tiles repeat every K+N+1 cycles
        start = 1'b1;
        tick();
        check("hold_c0_av", int'(a_valid), 1);
        first_c0 = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (first_c0 == 0 && a_valid == 2'b01) first_c0 = i;
        end
        start = 1'b0;
        check("hold_period", first_c0, K + N + 1);
        wait_ready("hold");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
